// File: rtl/logic_capture_if.sv
// Pin, byte-stream and status bundle for logic_capture.
// channel_mask exists only when LOGIC_CAPTURE_MASK_EN is defined.
interface logic_capture_if #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned DEPTH    = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [CHANNELS-1:0] pin_values;
`ifdef LOGIC_CAPTURE_MASK_EN
  logic [CHANNELS-1:0] channel_mask;
`endif
  logic [7:0]          byte_out;
  logic                byte_valid;
  logic                byte_ready;
  logic [LVL_W-1:0]    fifo_level;
  logic                overflow;

`ifdef LOGIC_CAPTURE_MASK_EN
  modport master (
    input  pin_values, channel_mask, byte_ready,
    output byte_out, byte_valid, fifo_level, overflow
  );
  modport slave (
    output pin_values, channel_mask, byte_ready,
    input  byte_out, byte_valid, fifo_level, overflow
  );
`else
  modport master (
    input  pin_values, byte_ready,
    output byte_out, byte_valid, fifo_level, overflow
  );
  modport slave (
    output pin_values, byte_ready,
    input  byte_out, byte_valid, fifo_level, overflow
  );
`endif
endinterface

// File: rtl/logic_capture.sv
// Logic analyser capture path: sync + change detect, timestamped record FIFO, byte serializer.
// Optional per-channel event mask via macro LOGIC_CAPTURE_MASK_EN.
module logic_capture #(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned TIME_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic            clk,
  input  logic            rst,
  logic_capture_if.master cap
);
  localparam int unsigned REC_W  = TIME_WIDTH + CHANNELS;
  localparam int unsigned NBYTES = REC_W / 8;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LVL_W  = AW + 1;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [CHANNELS-1:0]   r_sync1, r_sync2, r_prev;
  logic [TIME_WIDTH-1:0] r_counter;
  logic                  r_primed;
  logic [REC_W-1:0]      r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_overflow;
  logic [REC_W-1:0]      r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_valid;
  state_t                r_state, w_state_nxt;

  logic w_change, w_wrap, w_event, w_full, w_empty, w_push, w_pop, w_shift, w_hs;

`ifdef LOGIC_CAPTURE_MASK_EN
  assign w_change = |((r_sync2 ^ r_prev) & cap.channel_mask);
`else
  assign w_change = (r_sync2 != r_prev);
`endif
  assign w_wrap  = r_primed & (r_counter == '0);
  assign w_event = w_change | w_wrap | ~r_primed;
  // full/empty come from the pre-edge level, so a pop never makes room for a same-cycle push
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = w_event & ~w_full;
  assign w_hs    = r_valid & cap.byte_ready;

  // Synchroniser, change history, timestamp counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_counter <= '0;
      r_primed  <= 1'b0;
    end else begin
      r_sync1   <= cap.pin_values;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_counter <= r_counter + TIME_WIDTH'(1);
      r_primed  <= 1'b1;
    end
  end

  // Record storage has no reset; validity is tracked by pointers and level
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_counter, r_sync2};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_event && w_full) r_overflow <= 1'b1;
    end
  end

  // Serializer next-state: pop on idle or on the last-byte handshake
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (r_idx == IDX_W'(NBYTES - 1)) begin
            if (!w_empty) w_pop = 1'b1;
            else          w_state_nxt = S_IDLE;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_SEND);
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
        r_idx   <= '0;
      end else if (w_shift) begin
        r_shift <= r_shift << 8;
        r_idx   <= r_idx + IDX_W'(1);
      end
    end
  end

  assign cap.byte_out   = r_shift[REC_W-1 -: 8];
  assign cap.byte_valid = r_valid;
  assign cap.fifo_level = r_level;
  assign cap.overflow   = r_overflow;

endmodule
